// File: rtl/mips_cpu_pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_pc_sequencer_if
//  Description : Decoder/ALU <-> PC sequencer bundle. The master side presents
//                the executing instruction's control and operands; the slave
//                side (the sequencer) returns the PC and its status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_cpu_pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              instr_valid;
  logic              stall;
  logic [1:0]        pc_sel;
  logic              is_true;
  logic [31:0]       extended_imm;
  logic [25:0]       j_addr;
  logic [ADDR_W-1:0] reg_data_a;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] link_pc;
  logic              in_delay_slot;
  logic              active;
  logic              addr_err;

  modport master (
    output instr_valid, stall, pc_sel, is_true, extended_imm, j_addr, reg_data_a,
    input  pc, link_pc, in_delay_slot, active, addr_err
  );

  modport slave (
    input  instr_valid, stall, pc_sel, is_true, extended_imm, j_addr, reg_data_a,
    output pc, link_pc, in_delay_slot, active, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_pc_sequencer
//  Description : Registered MIPS program counter. Computes increment, branch,
//                jump and jump-register targets, implements the single branch
//                delay slot through a pending-target register, honours fetch
//                stalls and halts permanently on a redirect to address 0.
//  Option      : PC_MISALIGN_EXC_EN - a misaligned JR target is replaced by
//                EXC_VECTOR and addr_err pulses when it reaches the PC.
//                Without it the JR target is word-aligned and addr_err is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_pc_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int                BR_OFF_W     = 18
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  mips_cpu_pc_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DELAY = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_INC    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_JR     = 2'b11;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_q, pc_nx;
  logic [ADDR_W-1:0] pend_q, pend_nx;
  logic              pend_exc_q, pend_exc_nx;
  logic              err_q, err_nx;

  logic              advance;
  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic              jr_misalign;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_exc;
  logic              redirect;

  // The halted state swallows every instruction, so it gates advance directly.
  assign advance = bus.instr_valid & ~bus.stall & (state != ST_HALT);
  assign pc4     = pc_q + ADDR_W'(4);

  // Branch offset: only the low BR_OFF_W bits of (imm << 2) count, sign-extended.
  assign br_off = {{(ADDR_W-BR_OFF_W){bus.extended_imm[BR_OFF_W-3]}},
                   bus.extended_imm[BR_OFF_W-3:0], 2'b00};
  assign br_tgt = pc4 + br_off;

  // The immediate bits above the branch offset window never reach the PC.
  logic unused_imm_bits;
  assign unused_imm_bits = ^bus.extended_imm[31:BR_OFF_W-2];

  generate
    if (ADDR_W > 28) begin : g_jump_segment
      assign j_tgt = {pc4[ADDR_W-1:28], bus.j_addr, 2'b00};
    end else begin : g_jump_flat
      assign j_tgt = {bus.j_addr, 2'b00};
    end
  endgenerate

`ifdef PC_MISALIGN_EXC_EN
  assign jr_misalign = |bus.reg_data_a[1:0];
  assign jr_tgt      = jr_misalign ? EXC_VECTOR : bus.reg_data_a;
`else
  assign jr_misalign = 1'b0;
  assign jr_tgt      = {bus.reg_data_a[ADDR_W-1:2], 2'b00};

  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{bus.reg_data_a[1:0], EXC_VECTOR};
`endif

  // Select the redirect target for the instruction at pc and decide if it is taken.
  always_comb begin
    redirect = 1'b0;
    tgt      = pc4;
    tgt_exc  = 1'b0;
    case (bus.pc_sel)
      SEL_BRANCH: begin
        redirect = bus.is_true;
        tgt      = br_tgt;
      end
      SEL_JUMP: begin
        redirect = 1'b1;
        tgt      = j_tgt;
      end
      SEL_JR: begin
        redirect = 1'b1;
        tgt      = jr_tgt;
        tgt_exc  = jr_misalign;
      end
      default: begin
        redirect = 1'b0;
      end
    endcase
  end

  // Next-state logic: a taken redirect first steps into the delay slot, and the
  // slot's own control-flow request is dropped when the pending target is used.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc_q;
    pend_nx     = pend_q;
    pend_exc_nx = pend_exc_q;
    err_nx      = 1'b0;
    case (state)
      ST_RUN: begin
        if (advance) begin
          pc_nx = pc4;
          if (redirect) begin
            pend_nx     = tgt;
            pend_exc_nx = tgt_exc;
            state_nx    = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        if (advance) begin
          pc_nx       = pend_q;
          err_nx      = pend_exc_q;
          pend_nx     = '0;
          pend_exc_nx = 1'b0;
          state_nx    = (pend_q == '0) ? ST_HALT : ST_RUN;
        end
      end
      ST_HALT: begin
        pc_nx = '0;
      end
      default: begin
        state_nx = ST_RUN;
      end
    endcase
  end

  // State, PC and pending-target registers; reset discards any pending redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      pend_q     <= '0;
      pend_exc_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nx;
      pc_q       <= pc_nx;
      pend_q     <= pend_nx;
      pend_exc_q <= pend_exc_nx;
      err_q      <= err_nx;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.link_pc       = pc_q + ADDR_W'(8);
  assign bus.in_delay_slot = (state == ST_DELAY);
  assign bus.active        = (state != ST_HALT);
  assign bus.addr_err      = err_q;

endmodule
`default_nettype wire
